// File: rtl/rand_pkg.sv
// Shared types and helpers for the random-request arbiter and its LFSR core.
package rand_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 8'h01;
  localparam logic [LFSR_W-1:0] LFSR_RESET    = 8'hFF;

  typedef enum logic [1:0] {
    LOAD,
    WARMUP,
    IDLE,
    DRAW
  } state_e;

  // Smallest all-ones pattern covering limit: smear the top set bit downwards.
  function automatic logic [LFSR_W-1:0] mask_of(input logic [LFSR_W-1:0] limit);
    logic [LFSR_W-1:0] m;
    m = limit;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/rand_lfsr_core.sv
// 8-bit Fibonacci LFSR register; load has priority over step, q_next is the
// value the register would take on a step.
module rand_lfsr_core
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] q_next
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  assign q_next = lfsr_advance(lfsr_q);
  assign q      = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_val;
    end else if (step) begin
      lfsr_d = q_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_RESET;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/rand_req_arbiter.sv
// Round-robin arbiter sharing one LFSR among N requesters, with bounded draws by
// masked rejection sampling. Define RAND_STATS_EN to add the rej_cnt_o counter.
module rand_req_arbiter
  import rand_pkg::*;
#(
  parameter int N          = 4,
  parameter int WARMUP_CYC = 4,
  parameter int MAX_TRIES  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     seed_i,
  input  logic           reseed_i,
  input  logic [N-1:0]   req_i,
  input  logic [8*N-1:0] lim_i,
  output logic [N-1:0]   gnt_o,
  output logic [7:0]     rnd_o,
  output logic           busy_o
`ifdef RAND_STATS_EN
  ,
  output logic [15:0]    rej_cnt_o
`endif
);

  localparam int IDX_W = $clog2(N);
  localparam int ATT_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [ATT_W-1:0] LAST_ATT  = ATT_W'(MAX_TRIES - 1);
  localparam logic [7:0]       WARM_LAST = 8'(WARMUP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_EXT     = (IDX_W + 1)'(N);

  state_e            state_q, state_d;
  logic [7:0]        warm_cnt_q, warm_cnt_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        lim_q, lim_d;
  logic [7:0]        mask_q, mask_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [7:0]        rnd_q, rnd_d;

  logic              lfsr_load, lfsr_step;
  logic [7:0]        seed_sel;
  logic [7:0]        lfsr_cur, lfsr_next;
  logic              unused_lfsr_cur;

  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W:0]    scan_sum;
  logic [IDX_W-1:0]  scan_idx;
  logic [7:0]        win_lim;

  logic [7:0]        cand;
  logic [7:0]        fallback;
  logic              reject;
  logic              last_try;

  // An all-zero seed would lock the LFSR, so it is substituted on load.
  assign seed_sel = (seed_i == 8'h00) ? SEED_ZERO_SUB : seed_i;

  rand_lfsr_core u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (seed_sel),
    .step     (lfsr_step),
    .q        (lfsr_cur),
    .q_next   (lfsr_next)
  );

  // Draws consume the stepped value, so the current register is only observable.
  assign unused_lfsr_cur = ^lfsr_cur;

  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      if (scan_sum >= N_EXT) begin
        scan_sum = scan_sum - N_EXT;
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!win_vld && req_i[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    win_lim = '0;
    for (int k = 0; k < N; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_lim = lim_i[8*k +: 8];
      end
    end
  end

  assign cand     = lfsr_next & mask_q;
  assign reject   = cand > lim_q;
  assign last_try = (att_q == LAST_ATT);
  // Folding an out-of-range candidate down by (limit+1) keeps it within range.
  assign fallback = cand - lim_q - 8'd1;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    att_d      = att_q;
    idx_d      = idx_q;
    lim_d      = lim_q;
    mask_d     = mask_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    rnd_d      = rnd_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    if (reseed_i) begin
      state_d    = LOAD;
      warm_cnt_d = '0;
      att_d      = '0;
    end else begin
      case (state_q)
        LOAD: begin
          lfsr_load  = 1'b1;
          warm_cnt_d = '0;
          state_d    = (WARMUP_CYC == 0) ? IDLE : WARMUP;
        end
        WARMUP: begin
          lfsr_step = 1'b1;
          if (warm_cnt_q == WARM_LAST) begin
            warm_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            warm_cnt_d = warm_cnt_q + 8'd1;
          end
        end
        IDLE: begin
          if (win_vld) begin
            idx_d   = win_idx;
            lim_d   = win_lim;
            mask_d  = mask_of(win_lim);
            att_d   = '0;
            state_d = DRAW;
          end
        end
        DRAW: begin
          lfsr_step = 1'b1;
          if (!reject || last_try) begin
            gnt_d[idx_q] = 1'b1;
            rnd_d        = reject ? fallback : cand;
            rr_ptr_d     = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            att_d        = '0;
            state_d      = IDLE;
          end else begin
            att_d = att_q + 1'b1;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      warm_cnt_q <= '0;
      att_q      <= '0;
      idx_q      <= '0;
      lim_q      <= '0;
      mask_q     <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      rnd_q      <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      att_q      <= att_d;
      idx_q      <= idx_d;
      lim_q      <= lim_d;
      mask_q     <= mask_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      rnd_q      <= rnd_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign rnd_o  = rnd_q;
  assign busy_o = (state_q != IDLE);

`ifdef RAND_STATS_EN
  // Every rejected candidate counts, including one replaced by the fallback.
  logic [15:0] rej_cnt_q, rej_cnt_d;
  logic        rej_evt;

  assign rej_evt = (state_q == DRAW) && !reseed_i && reject;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (rej_evt && (rej_cnt_q != 16'hFFFF)) begin
      rej_cnt_d = rej_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_cnt_q <= '0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign rej_cnt_o = rej_cnt_q;
`endif

endmodule
